// File: rtl/nat_join_2_d_sync.sv
// Two-way unconditional join with data: collects one drive per upstream branch,
// issues a combined downstream drive when a credit is held, then frees both branches.
module nat_join_2_d_sync #(
   parameter int unsigned DATA_WIDTH = 10,
   parameter int unsigned FREE_DELAY = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_drive0,
   input  logic                      i_drive1,
   input  logic [DATA_WIDTH-1:0]     i_data0,
   input  logic [DATA_WIDTH-1:0]     i_data1,
   input  logic                      i_freeNext,
   output logic                      o_free0,
   output logic                      o_free1,
   output logic                      o_driveNext,
   output logic [2*DATA_WIDTH-1:0]   o_data,
   output logic [2:0]                o_err
);

   typedef enum logic {
      COLLECT   = 1'b0,
      FREE_WAIT = 1'b1
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(FREE_DELAY - 1);

   state_t                    state_q, state_d;
   logic                      arr0_q, arr0_d;
   logic                      arr1_q, arr1_d;
   logic [DATA_WIDTH-1:0]     data0_q, data0_d;
   logic [DATA_WIDTH-1:0]     data1_q, data1_d;
   logic                      credit_q, credit_d;
   logic [3:0]                cnt_q, cnt_d;
   logic                      drive_next_q, drive_next_d;
   logic                      free_q, free_d;
   logic [2*DATA_WIDTH-1:0]   data_out_q, data_out_d;
   logic [2:0]                err_q, err_d;

   logic                      fire;
   logic [DATA_WIDTH-1:0]     eff0;
   logic [DATA_WIDTH-1:0]     eff1;

   always_comb begin
      state_d      = state_q;
      arr0_d       = arr0_q;
      arr1_d       = arr1_q;
      data0_d      = data0_q;
      data1_d      = data1_q;
      credit_d     = credit_q;
      cnt_d        = cnt_q;
      drive_next_d = 1'b0;
      free_d       = 1'b0;
      data_out_d   = data_out_q;
      err_d        = err_q;
      fire         = 1'b0;
      // A branch arriving this cycle contributes its live data to the fire.
      eff0         = arr0_q ? data0_q : i_data0;
      eff1         = arr1_q ? data1_q : i_data1;

      if (i_freeNext) begin
         if (credit_q) begin
            err_d[2] = 1'b1;
         end else begin
            credit_d = 1'b1;
         end
      end

      unique case (state_q)
         COLLECT: begin
            if (i_drive0) begin
               if (arr0_q) begin
                  err_d[0] = 1'b1;
               end else begin
                  arr0_d  = 1'b1;
                  data0_d = i_data0;
               end
            end
            if (i_drive1) begin
               if (arr1_q) begin
                  err_d[1] = 1'b1;
               end else begin
                  arr1_d  = 1'b1;
                  data1_d = i_data1;
               end
            end
            fire = (arr0_q | i_drive0) & (arr1_q | i_drive1) & credit_q;
            if (fire) begin
               drive_next_d = 1'b1;
               data_out_d   = {eff1, eff0};
               arr0_d       = 1'b0;
               arr1_d       = 1'b0;
               credit_d     = 1'b0;
               cnt_d        = CNT_LOAD;
               state_d      = FREE_WAIT;
            end
         end
         FREE_WAIT: begin
            if (i_drive0) err_d[0] = 1'b1;
            if (i_drive1) err_d[1] = 1'b1;
            if (cnt_q == 4'd0) begin
               free_d  = 1'b1;
               state_d = COLLECT;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= COLLECT;
         arr0_q       <= 1'b0;
         arr1_q       <= 1'b0;
         data0_q      <= '0;
         data1_q      <= '0;
         credit_q     <= 1'b1;
         cnt_q        <= '0;
         drive_next_q <= 1'b0;
         free_q       <= 1'b0;
         data_out_q   <= '0;
         err_q        <= '0;
      end else begin
         state_q      <= state_d;
         arr0_q       <= arr0_d;
         arr1_q       <= arr1_d;
         data0_q      <= data0_d;
         data1_q      <= data1_d;
         credit_q     <= credit_d;
         cnt_q        <= cnt_d;
         drive_next_q <= drive_next_d;
         free_q       <= free_d;
         data_out_q   <= data_out_d;
         err_q        <= err_d;
      end
   end

   assign o_driveNext = drive_next_q;
   assign o_free0     = free_q;
   assign o_free1     = free_q;
   assign o_data      = data_out_q;
   assign o_err       = err_q;

endmodule

// File: tb/tb_nat_join_2_d_sync.sv
// Directed bench for nat_join_2_d_sync: main instance at FREE_DELAY=2 plus
// FREE_DELAY=1 and FREE_DELAY=15 instances sharing the same stimulus.
module tb_nat_join_2_d_sync;

   localparam int DW = 10;

   logic            clk;
   logic            rst;
   logic            d0, d1, fn;
   logic [DW-1:0]   da0, da1;

   logic            f0, f1, dn;
   logic [2*DW-1:0] dat;
   logic [2:0]      err;

   logic            f0_a, f1_a, dn_a;
   logic [2*DW-1:0] dat_a;
   logic [2:0]      err_a;

   logic            f0_b, f1_b, dn_b;
   logic [2*DW-1:0] dat_b;
   logic [2:0]      err_b;

   int checks = 0;
   int errors = 0;
   int dn_cnt = 0;
   int fr_cnt = 0;

   nat_join_2_d_sync #(.DATA_WIDTH(DW), .FREE_DELAY(2)) dut (
      .clk(clk), .rst(rst), .i_drive0(d0), .i_drive1(d1), .i_data0(da0), .i_data1(da1),
      .i_freeNext(fn), .o_free0(f0), .o_free1(f1), .o_driveNext(dn), .o_data(dat), .o_err(err));

   nat_join_2_d_sync #(.DATA_WIDTH(DW), .FREE_DELAY(1)) dut_d1 (
      .clk(clk), .rst(rst), .i_drive0(d0), .i_drive1(d1), .i_data0(da0), .i_data1(da1),
      .i_freeNext(fn), .o_free0(f0_a), .o_free1(f1_a), .o_driveNext(dn_a), .o_data(dat_a), .o_err(err_a));

   nat_join_2_d_sync #(.DATA_WIDTH(DW), .FREE_DELAY(15)) dut_d15 (
      .clk(clk), .rst(rst), .i_drive0(d0), .i_drive1(d1), .i_data0(da0), .i_data1(da1),
      .i_freeNext(fn), .o_free0(f0_b), .o_free1(f1_b), .o_driveNext(dn_b), .o_data(dat_b), .o_err(err_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Pulse counters on the main instance, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         dn_cnt = 0;
         fr_cnt = 0;
      end else begin
         if (dn) dn_cnt = dn_cnt + 1;
         if (f0 && f1) fr_cnt = fr_cnt + 1;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; d0 = 1'b0; d1 = 1'b0; fn = 1'b0; da0 = '0; da1 = '0;
      repeat (2) step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({dn, f0, f1} !== 3'b000) begin
         errors++; $display("FAIL reset_pulses: got %b exp 000", {dn, f0, f1});
      end
      checks++;
      if (dat !== '0) begin
         errors++; $display("FAIL reset_data: got %h exp 00000", dat);
      end
      checks++;
      if (err !== 3'b000) begin
         errors++; $display("FAIL reset_err: got %b exp 000", err);
      end
   endtask

   task automatic test_basic();
      do_reset();
      d0 = 1'b1; da0 = 10'h155; d1 = 1'b1; da1 = 10'h0AA;
      step();
      d0 = 1'b0; d1 = 1'b0;
      checks++;
      if (dn !== 1'b1 || f0 !== 1'b0) begin
         errors++; $display("FAIL basic_drive: got dn=%b f0=%b exp dn=1 f0=0", dn, f0);
      end
      checks++;
      if (dat !== 20'h2A955) begin
         errors++; $display("FAIL basic_data: got %h exp 2a955", dat);
      end
      step();
      checks++;
      if ({dn, f0, f1} !== 3'b000) begin
         errors++; $display("FAIL basic_gap: got %b exp 000", {dn, f0, f1});
      end
      step();
      checks++;
      if ({dn, f0, f1} !== 3'b011) begin
         errors++; $display("FAIL basic_free: got %b exp 011", {dn, f0, f1});
      end
      step();
      checks++;
      if ({dn, f0, f1} !== 3'b000 || dat !== 20'h2A955) begin
         errors++; $display("FAIL basic_after: got pulses=%b data=%h exp 000 2a955", {dn, f0, f1}, dat);
      end
   endtask

   task automatic test_skew();
      do_reset();
      d1 = 1'b1; da1 = 10'h3FF;
      step();
      d1 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (dn !== 1'b0) begin
            errors++; $display("FAIL skew_early: cycle %0d got dn=%b exp 0", i, dn);
         end
         step();
      end
      d0 = 1'b1; da0 = 10'h001;
      step();
      d0 = 1'b0;
      checks++;
      if (dn !== 1'b1 || dat !== 20'hFFC01) begin
         errors++; $display("FAIL skew_fire: got dn=%b data=%h exp 1 ffc01", dn, dat);
      end
      step();
      step();
      checks++;
      if ({f0, f1} !== 2'b11 || err !== 3'b000) begin
         errors++; $display("FAIL skew_free: got free=%b err=%b exp 11 000", {f0, f1}, err);
      end
   endtask

   task automatic test_no_credit();
      do_reset();
      d0 = 1'b1; da0 = 10'h011; d1 = 1'b1; da1 = 10'h022;
      step();
      d0 = 1'b0; d1 = 1'b0;
      repeat (4) step();
      d0 = 1'b1; da0 = 10'h033; d1 = 1'b1; da1 = 10'h044;
      step();
      d0 = 1'b0; d1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (dn !== 1'b0) begin
            errors++; $display("FAIL nocredit_hold: cycle %0d got dn=%b exp 0", i, dn);
         end
         step();
      end
      fn = 1'b1;
      step();
      fn = 1'b0;
      checks++;
      if (dn !== 1'b0) begin
         errors++; $display("FAIL nocredit_k1: got dn=%b exp 0", dn);
      end
      step();
      checks++;
      if (dn !== 1'b1 || dat !== 20'h11033) begin
         errors++; $display("FAIL nocredit_k2: got dn=%b data=%h exp 1 11033", dn, dat);
      end
      checks++;
      if (err !== 3'b000) begin
         errors++; $display("FAIL nocredit_err: got %b exp 000", err);
      end
   endtask

   task automatic test_violations();
      do_reset();
      d0 = 1'b1; da0 = 10'h12A;
      step();
      da0 = 10'h0FF;
      step();
      d0 = 1'b0;
      checks++;
      if (err !== 3'b001) begin
         errors++; $display("FAIL viol_double0: got %b exp 001", err);
      end
      fn = 1'b1;
      step();
      fn = 1'b0;
      checks++;
      if (err !== 3'b101) begin
         errors++; $display("FAIL viol_credit: got %b exp 101", err);
      end
      d1 = 1'b1; da1 = 10'h2B4;
      step();
      d1 = 1'b0;
      checks++;
      if (dn !== 1'b1 || dat !== 20'hAD12A) begin
         errors++; $display("FAIL viol_keep: got dn=%b data=%h exp 1 ad12a", dn, dat);
      end
      d1 = 1'b1;
      step();
      d1 = 1'b0;
      checks++;
      if (err !== 3'b111) begin
         errors++; $display("FAIL viol_freewait: got %b exp 111", err);
      end
      repeat (5) step();
      checks++;
      if (err !== 3'b111) begin
         errors++; $display("FAIL viol_sticky: got %b exp 111", err);
      end
      do_reset();
      checks++;
      if (err !== 3'b000) begin
         errors++; $display("FAIL viol_clear: got %b exp 000", err);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      d0 = 1'b1; da0 = 10'h0F0; d1 = 1'b1; da1 = 10'h10F;
      step();
      d0 = 1'b0; d1 = 1'b0;
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if ({dn, f0, f1} !== 3'b000) begin
            errors++; $display("FAIL midreset_quiet: cycle %0d got %b exp 000", i, {dn, f0, f1});
         end
         step();
      end
      checks++;
      if (dat !== '0 || err !== 3'b000) begin
         errors++; $display("FAIL midreset_state: got data=%h err=%b exp 00000 000", dat, err);
      end
      d0 = 1'b1; da0 = 10'h005; d1 = 1'b1; da1 = 10'h00A;
      step();
      d0 = 1'b0; d1 = 1'b0;
      checks++;
      if (dn !== 1'b1 || dat !== 20'h02805) begin
         errors++; $display("FAIL midreset_fire: got dn=%b data=%h exp 1 02805", dn, dat);
      end
   endtask

   task automatic test_free_delay();
      int first_m, first_a, first_b, n_m, n_a, n_b;
      first_m = -1; first_a = -1; first_b = -1; n_m = 0; n_a = 0; n_b = 0;
      do_reset();
      d0 = 1'b1; da0 = 10'h1C3; d1 = 1'b1; da1 = 10'h03C;
      step();
      d0 = 1'b0; d1 = 1'b0;
      checks++;
      if ({dn, dn_a, dn_b} !== 3'b111) begin
         errors++; $display("FAIL delay_drive: got %b exp 111", {dn, dn_a, dn_b});
      end
      for (int i = 1; i <= 20; i++) begin
         step();
         if (f0 && f1)     begin if (first_m < 0) first_m = i; n_m++; end
         if (f0_a && f1_a) begin if (first_a < 0) first_a = i; n_a++; end
         if (f0_b && f1_b) begin if (first_b < 0) first_b = i; n_b++; end
      end
      checks++;
      if (first_a !== 1 || n_a !== 1) begin
         errors++; $display("FAIL delay1: got at %0d x%0d exp at 1 x1", first_a, n_a);
      end
      checks++;
      if (first_m !== 2 || n_m !== 1) begin
         errors++; $display("FAIL delay2: got at %0d x%0d exp at 2 x1", first_m, n_m);
      end
      checks++;
      if (first_b !== 15 || n_b !== 1) begin
         errors++; $display("FAIL delay15: got at %0d x%0d exp at 15 x1", first_b, n_b);
      end
   endtask

   task automatic test_back_to_back();
      int unsigned sk0, sk1;
      logic [DW-1:0] v0, v1;
      do_reset();
      for (int it = 0; it < 100; it++) begin
         sk0 = $urandom_range(0, 4);
         sk1 = $urandom_range(0, 4);
         v0 = DW'($urandom);
         v1 = DW'($urandom);
         for (int unsigned c = 0; c < 5; c++) begin
            d0 = (c == sk0); d1 = (c == sk1);
            if (c == sk0) da0 = v0;
            if (c == sk1) da1 = v1;
            step();
            d0 = 1'b0; d1 = 1'b0;
         end
         for (int b = 0; b < 10 && dn_cnt < it + 1; b++) step();
         checks++;
         if (dn_cnt !== it + 1) begin
            errors++; $display("FAIL b2b_drive: iter %0d got %0d pulses exp %0d", it, dn_cnt, it + 1);
         end
         checks++;
         if (dat !== {v1, v0}) begin
            errors++; $display("FAIL b2b_data: iter %0d got %h exp %h", it, dat, {v1, v0});
         end
         for (int b = 0; b < 10 && fr_cnt < it + 1; b++) step();
         checks++;
         if (fr_cnt !== it + 1) begin
            errors++; $display("FAIL b2b_free: iter %0d got %0d pulses exp %0d", it, fr_cnt, it + 1);
         end
         fn = 1'b1;
         step();
         fn = 1'b0;
      end
      repeat (4) step();
      checks++;
      if (dn_cnt !== 100 || fr_cnt !== 100 || err !== 3'b000) begin
         errors++; $display("FAIL b2b_total: got drives=%0d frees=%0d err=%b exp 100 100 000", dn_cnt, fr_cnt, err);
      end
   endtask

   initial begin
      rst = 1'b0; d0 = 1'b0; d1 = 1'b0; fn = 1'b0; da0 = '0; da1 = '0;
      test_reset();
      test_basic();
      test_skew();
      test_no_credit();
      test_violations();
      test_reset_mid();
      test_free_delay();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
